fifo_flush_sched: RTL and testbench

- Round-robin scheduler that shares one flush-read FIFO between NUM_REQ requesters.
- Sequences the FIFO flush handshake for each requester:
  - raises the flush line;
  - waits the fixed flush latency;
  - captures the 32-bit flush word (8 nibbles, 0xC-padded);
  - returns the word to the granted requester over a valid/ready response.
- Sits between the consumer clients and the fifo flush datapath.

---
 rtl/fifo_flush_sched.sv | 136 +++++++++++++
 tb/tb_fifo_flush_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flush_sched.sv
// Round-robin scheduler sharing one flush-read FIFO among NUM_REQ requesters.
// Define FLUSH_EMPTY_BYPASS_EN to skip the flush and return 32'hCCCC_CCCC when the FIFO is empty at grant.
module fifo_flush_sched #(
    parameter int NUM_REQ     = 4,
    parameter int CAPTURE_DLY = 2,
    parameter int GAP_CYC     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] resp_ready_i,
    output logic [NUM_REQ-1:0] resp_valid_o,
    output logic [31:0]        resp_data_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               fifo_flush_o,
    input  logic [31:0]        fifo_rd_data_i,
    input  logic               fifo_empty_i,
    output logic [15:0]        flush_cnt_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 16;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FLUSH, RESP, GAP} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]      own_idx, own_idx_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [31:0]        data_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [15:0]        flush_cnt_nxt;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      cand;

`ifndef FLUSH_EMPTY_BYPASS_EN
    logic unused_empty;
    assign unused_empty = fifo_empty_i;
`endif

    // First requester at or above the RR pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign busy_o = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        own_idx_nxt   = own_idx;
        grant_nxt     = grant_o;
        data_nxt      = resp_data_o;
        cnt_nxt       = cnt;
        flush_cnt_nxt = flush_cnt_o;
        fifo_flush_o  = 1'b0;
        resp_valid_o  = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt   = ONE << pick_idx;
                    own_idx_nxt = pick_idx;
                    cnt_nxt     = '0;
`ifdef FLUSH_EMPTY_BYPASS_EN
                    if (fifo_empty_i) begin
                        data_nxt  = 32'hCCCC_CCCC;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = FLUSH;
                    end
`else
                    state_nxt = FLUSH;
`endif
                end
            end
            FLUSH: begin
                fifo_flush_o = 1'b1;
                cnt_nxt      = cnt + 1'b1;
                if (cnt == CW'(CAPTURE_DLY)) begin
                    data_nxt  = fifo_rd_data_i;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid_o = grant_o;
                if (|(resp_ready_i & grant_o)) begin
                    if (flush_cnt_o != 16'hFFFF)
                        flush_cnt_nxt = flush_cnt_o + 1'b1;
                    rr_ptr_nxt = (own_idx == IW'(NUM_REQ-1)) ? '0 : own_idx + 1'b1;
                    grant_nxt  = '0;
                    cnt_nxt    = '0;
                    state_nxt  = GAP;
                end
            end
            GAP: begin
                // Flush must stay low long enough for the FIFO to re-arm.
                if (cnt == CW'(GAP_CYC-1))
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            own_idx     <= '0;
            grant_o     <= '0;
            resp_data_o <= '0;
            cnt         <= '0;
            flush_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            own_idx     <= own_idx_nxt;
            grant_o     <= grant_nxt;
            resp_data_o <= data_nxt;
            cnt         <= cnt_nxt;
            flush_cnt_o <= flush_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_flush_sched.sv
// Scoreboard bench for fifo_flush_sched: stimulus pushes expected responses, a negedge monitor checks them.
module tb_fifo_flush_sched;
    localparam int NUM_REQ     = 4;
    localparam int CAPTURE_DLY = 2;
    localparam int GAP_CYC     = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] resp_ready_i;
    logic [NUM_REQ-1:0] resp_valid_o;
    logic [31:0]        resp_data_o;
    logic [NUM_REQ-1:0] grant_o;
    logic               busy_o;
    logic               fifo_flush_o;
    logic [31:0]        fifo_rd_data_i;
    logic               fifo_empty_i;
    logic [15:0]        flush_cnt_o;

    fifo_flush_sched #(
        .NUM_REQ(NUM_REQ), .CAPTURE_DLY(CAPTURE_DLY), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .resp_ready_i(resp_ready_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .grant_o(grant_o),
        .busy_o(busy_o), .fifo_flush_o(fifo_flush_o), .fifo_rd_data_i(fifo_rd_data_i),
        .fifo_empty_i(fifo_empty_i), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0] g;
        logic [31:0]        d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vld_cycles = 0;
    int   pulses = 0;
    int   flush_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [NUM_REQ-1:0] g, input logic [31:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q_empty(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy_o) break;
            tick();
        end
        chk("idle_timeout", {31'd0, busy_o}, 0);
    endtask

    // Hold the request until every queued response has been taken, then drop it.
    task automatic txn(input logic [NUM_REQ-1:0] r, input int n);
        req_i = r;
        wait_q_empty(60 * n);
        req_i = '0;
        wait_idle(20);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req_i = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Monitor: flush pulse width, flush never high during a response, response order and data.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                flush_run = 0;
            end else begin
                if (fifo_flush_o) begin
                    flush_run++;
                end else if (flush_run != 0) begin
                    chk("flush_len", flush_run, CAPTURE_DLY + 1);
                    pulses++;
                    flush_run = 0;
                end
                if (resp_valid_o != '0) begin
                    vld_cycles++;
                    chk("flush_in_resp", {31'd0, fifo_flush_o}, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", {28'd0, resp_valid_o}, 0);
                    end else begin
                        chk("resp_owner", {28'd0, resp_valid_o}, {28'd0, exp_q[0].g});
                        chk("resp_data", resp_data_o, exp_q[0].d);
                        if ((resp_valid_o & resp_ready_i) != '0) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        req_i = '0;
        resp_ready_i = '0;
        fifo_rd_data_i = '0;
        fifo_empty_i = 1'b0;
        #12;
        chk("rst_grant", {28'd0, grant_o}, 0);
        chk("rst_valid", {28'd0, resp_valid_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_flush", {31'd0, fifo_flush_o}, 0);
        chk("rst_cnt", {16'd0, flush_cnt_o}, 0);
        chk("rst_data", resp_data_o, 0);
        tick();
        reset = 1'b1;

        // Reset in the 2nd flush cycle aborts with no response.
        fifo_rd_data_i = 32'hCCCC_C0A0;
        req_i = 4'b0001;
        tick();
        chk("abort_grant", {28'd0, grant_o}, 32'h1);
        chk("abort_flush_on", {31'd0, fifo_flush_o}, 1);
        tick();
        #2;
        reset = 1'b0;
        req_i = '0;
        #1;
        chk("abort_flush_off", {31'd0, fifo_flush_o}, 0);
        chk("abort_grant_clr", {28'd0, grant_o}, 0);
        chk("abort_busy", {31'd0, busy_o}, 0);
        tick();
        reset = 1'b1;
        resp_ready_i = 4'b1111;
        push(4'b0100, 32'hCCCC_C0A0);
        req_i = 4'b0100;
        chk("post_rst_nogrant", {28'd0, grant_o}, 0);
        tick();
        chk("post_rst_grant", {28'd0, grant_o}, 32'h4);
        txn(4'b0100, 1);
        chk("post_rst_cnt", {16'd0, flush_cnt_o}, 1);

        // Single requester.
        vld_cycles = 0;
        pulses = 0;
        fifo_rd_data_i = 32'hCCCC_C321;
        push(4'b0001, 32'hCCCC_C321);
        txn(4'b0001, 1);
        chk("single_cnt", {16'd0, flush_cnt_o}, 2);
        chk("single_vld_cycles", vld_cycles, 1);
        chk("single_pulses", pulses, 1);

        // Round robin from a fresh pointer, all four requesting.
        apply_reset();
        chk("rr_cnt_clr", {16'd0, flush_cnt_o}, 0);
        pulses = 0;
        fifo_rd_data_i = 32'hCCCC_CB0B;
        for (int i = 0; i < 8; i++) push(4'b0001 << (i % 4), 32'hCCCC_CB0B);
        txn(4'b1111, 8);
        chk("rr_cnt", {16'd0, flush_cnt_o}, 8);
        chk("rr_pulses", pulses, 8);

        // Sparse requests 1 and 3: pointer starts at 0.
        fifo_rd_data_i = 32'hCCCC_CA1A;
        push(4'b0010, 32'hCCCC_CA1A);
        push(4'b1000, 32'hCCCC_CA1A);
        push(4'b0010, 32'hCCCC_CA1A);
        txn(4'b1010, 3);
        chk("sparse_cnt", {16'd0, flush_cnt_o}, 11);

        // Backpressure on requester 2; ready from requester 1 alone is ignored.
        vld_cycles = 0;
        pulses = 0;
        resp_ready_i = '0;
        fifo_rd_data_i = 32'hCCCC_C777;
        push(4'b0100, 32'hCCCC_C777);
        req_i = 4'b0100;
        tick();
        chk("bp_grant", {28'd0, grant_o}, 32'h4);
        req_i = '0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid_o != '0) break;
            tick();
        end
        chk("bp_valid_seen", {28'd0, resp_valid_o}, 32'h4);
        fifo_rd_data_i = 32'hDEAD_BEEF;
        repeat (4) tick();
        resp_ready_i = 4'b0010;
        tick();
        resp_ready_i = 4'b0100;
        wait_q_empty(10);
        resp_ready_i = 4'b1111;
        wait_idle(20);
        chk("bp_vld_cycles", vld_cycles, 6);
        chk("bp_pulses", pulses, 1);
        chk("bp_cnt", {16'd0, flush_cnt_o}, 12);

        // Requester 3 drops its request right after grant; requester 0 is served next.
        fifo_rd_data_i = 32'hCCCC_C3D3;
        push(4'b1000, 32'hCCCC_C3D3);
        push(4'b0001, 32'hCCCC_C3D3);
        req_i = 4'b1001;
        tick();
        chk("drop_grant", {28'd0, grant_o}, 32'h8);
        req_i = 4'b0001;
        wait_q_empty(40);
        req_i = '0;
        wait_idle(20);
        chk("drop_cnt", {16'd0, flush_cnt_o}, 14);

        // Empty FIFO at grant.
        pulses = 0;
        fifo_empty_i = 1'b1;
        fifo_rd_data_i = 32'hCCCC_C5E5;
`ifdef FLUSH_EMPTY_BYPASS_EN
        push(4'b0010, 32'hCCCC_CCCC);
`else
        push(4'b0010, 32'hCCCC_C5E5);
`endif
        req_i = 4'b0010;
        tick();
        chk("empty_grant", {28'd0, grant_o}, 32'h2);
`ifdef FLUSH_EMPTY_BYPASS_EN
        chk("bypass_data", resp_data_o, 32'hCCCC_CCCC);
`endif
        req_i = '0;
        wait_q_empty(20);
        wait_idle(20);
        fifo_empty_i = 1'b0;
`ifdef FLUSH_EMPTY_BYPASS_EN
        chk("empty_pulses", pulses, 0);
`else
        chk("empty_pulses", pulses, 1);
`endif
        chk("final_cnt", {16'd0, flush_cnt_o}, 15);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
